sample_accum: RTL and testbench

SAMPLE_ACCUM -- requirements
Module: sample_accum

---
 rtl/sample_accum_pkg.sv | 14 +
 rtl/sample_ext.sv | 23 ++
 rtl/sample_accum.sv | 95 +++++++++
 tb/tb_sample_accum.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sample_accum_pkg.sv
// Shared constants for the sample block accumulator: default sample width,
// default block length exponent, and the block-sum width derivation.
package sample_accum_pkg;

    localparam int BW_IN_DEFAULT  = 32'sd3;
    localparam int LOG2_N_DEFAULT = 32'sd2;

    // Width of a block sum: N = 2**log2_n samples of bw_in bits each
    // need log2_n extra bits so uniformly signed/unsigned blocks never overflow.
    function automatic int bw_out_of(input int bw_in, input int log2_n);
        return bw_in + log2_n;
    endfunction

endpackage

// File: rtl/sample_ext.sv
// Widens one narrow sample to the block-sum width, choosing sign or zero
// extension per sample from data_is_signed.
module sample_ext
    import sample_accum_pkg::*;
#(
    parameter int BW_IN  = BW_IN_DEFAULT,
    parameter int BW_OUT = bw_out_of(BW_IN_DEFAULT, LOG2_N_DEFAULT)
) (
    input  logic              data_is_signed,
    input  logic [BW_IN-1:0]  data_in,
    output logic [BW_OUT-1:0] ext
);

    // Replicate the sample MSB for signed samples, zeros for unsigned ones.
    always_comb begin
        if (data_is_signed) begin
            ext = {{(BW_OUT-BW_IN){data_in[BW_IN-1]}}, data_in};
        end else begin
            ext = {{(BW_OUT-BW_IN){1'b0}}, data_in};
        end
    end

endmodule

// File: rtl/sample_accum.sv
// Block accumulator: sums N = 2**LOG2_N extended samples and presents each
// block sum on a valid/ready output. A completed sum is held until taken;
// while it waits, no further input is accepted.
module sample_accum
    import sample_accum_pkg::*;
#(
    parameter int BW_IN  = BW_IN_DEFAULT,
    parameter int LOG2_N = LOG2_N_DEFAULT,
    parameter int BW_OUT = bw_out_of(BW_IN, LOG2_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              data_is_signed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BW_IN-1:0]  data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BW_OUT-1:0] data_out
);

    localparam int                N        = 32'sd1 << LOG2_N;
    localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(32'sd1);
    localparam logic [LOG2_N-1:0] CNT_LAST = LOG2_N'(N - 32'sd1);

    logic [BW_OUT-1:0] ext_s;
    logic [BW_OUT-1:0] sum_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              wrap_s;

    logic [BW_OUT-1:0] acc_r;
    logic [LOG2_N-1:0] cnt_r;
    logic [BW_OUT-1:0] data_out_r;
    logic              out_valid_r;

    sample_ext #(
        .BW_IN  (BW_IN),
        .BW_OUT (BW_OUT)
    ) u_sample_ext (
        .data_is_signed (data_is_signed),
        .data_in        (data_in),
        .ext            (ext_s)
    );

    // Ready unless flushing, in reset, or holding an untaken sum; an accept on
    // the last slot of a block completes it.
    always_comb begin
        if (rst) begin
            in_ready_s = 1'b0;
        end else if (clear) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = ~out_valid_r | out_ready;
        end
        accept_s = in_valid & in_ready_s;
        wrap_s   = accept_s & (cnt_r == CNT_LAST);
        sum_s    = acc_r + ext_s;
    end

    // Accumulate samples, publish the sum on block completion, retire it on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r       <= {BW_OUT{1'b0}};
            cnt_r       <= {LOG2_N{1'b0}};
            data_out_r  <= {BW_OUT{1'b0}};
            out_valid_r <= 1'b0;
        end else if (clear) begin
            // Flush only the partial block; a pending output stays untouched.
            acc_r <= {BW_OUT{1'b0}};
            cnt_r <= {LOG2_N{1'b0}};
        end else begin
            if (accept_s) begin
                cnt_r <= cnt_r + CNT_ONE;
                if (wrap_s) begin
                    acc_r <= {BW_OUT{1'b0}};
                end else begin
                    acc_r <= sum_s;
                end
            end
            if (wrap_s) begin
                data_out_r  <= sum_s;
                out_valid_r <= 1'b1;
            end else if (out_valid_r & out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign data_out  = data_out_r;

endmodule

// File: tb/tb_sample_accum.sv
// Directed bench for sample_accum (BW_IN=3, LOG2_N=2): a cycle model predicts
// in_ready/out_valid, expected block sums are queued when the completing
// sample is driven and popped when the output should appear.
module tb_sample_accum;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       data_is_signed;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] data_in;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] data_out;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q[$];
    logic [4:0] m_acc;
    int         m_cnt;
    logic       m_ov;
    logic [4:0] m_dout;

    always #5 clk = ~clk;

    sample_accum #(
        .BW_IN  (3),
        .LOG2_N (2),
        .BW_OUT (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .data_is_signed (data_is_signed),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_in        (data_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data_out       (data_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic cycle(input string tag, input logic iv, input logic [2:0] d,
                         input logic s, input logic ordy, input logic clr);
        logic       exp_rdy;
        logic       done;
        logic [4:0] ext;
        logic [4:0] sum;
        in_valid       = iv;
        data_in        = d;
        data_is_signed = s;
        out_ready      = ordy;
        clear          = clr;
        #1;
        exp_rdy = !clr && (!m_ov || ordy);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
        done = 1'b0;
        if (iv && exp_rdy) begin
            ext = s ? 5'($signed(d)) : {2'b00, d};
            sum = m_acc + ext;
            if (m_cnt == 3) begin
                exp_q.push_back(sum);
                m_acc = 5'd0;
                m_cnt = 0;
                done  = 1'b1;
            end else begin
                m_acc = sum;
                m_cnt = m_cnt + 1;
            end
        end
        if (clr) begin
            m_acc = 5'd0;
            m_cnt = 0;
        end
        @(posedge clk);
        #1;
        if (done) begin
            m_ov   = 1'b1;
            m_dout = exp_q.pop_front();
        end else if (!clr && m_ov && ordy) begin
            m_ov = 1'b0;
        end
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_ov});
        chk({tag, ".data_out"}, {27'd0, data_out}, {27'd0, m_dout});
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic model_reset();
        m_acc  = 5'd0;
        m_cnt  = 0;
        m_ov   = 1'b0;
        m_dout = 5'd0;
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; data_is_signed = 1'b0;
        in_valid = 1'b1; data_in = 3'd0; out_ready = 1'b1;
        model_reset();
        #3;
        chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset.data_out", {27'd0, data_out}, 32'd0);
        chk("reset.in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Unsigned 7 x4 -> 28, visible right after the 4th accept.
        for (int i = 0; i < 4; i++) cycle("u7", 1'b1, 3'd7, 1'b0, 1'b1, 1'b0);
        chk("u7.sum", {27'd0, data_out}, 32'd28);
        cycle("u7.drain", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

        // Signed -4 x4 -> -16 (5'b10000).
        for (int i = 0; i < 4; i++) cycle("s4", 1'b1, 3'b100, 1'b1, 1'b1, 1'b0);
        chk("s4.sum", {27'd0, data_out}, 32'd16);
        cycle("s4.drain", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

        // Mixed signedness: -1 + 7 + 0 + 0 -> 6.
        cycle("mix", 1'b1, 3'b111, 1'b1, 1'b1, 1'b0);
        cycle("mix", 1'b1, 3'b111, 1'b0, 1'b1, 1'b0);
        cycle("mix", 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
        cycle("mix", 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        chk("mix.sum", {27'd0, data_out}, 32'd6);
        cycle("mix.drain", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

        // Backpressure: hold 4 for 5 cycles, then release while offering a sample.
        for (int i = 0; i < 4; i++) cycle("bp.fill", 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle("bp.hold", 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
            chk("bp.hold.sum", {27'd0, data_out}, 32'd4);
        end
        cycle("bp.release", 1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        chk("bp.release.out_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 3; i++) cycle("bp.next", 1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        chk("bp.next.sum", {27'd0, data_out}, 32'd8);
        cycle("bp.drain", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

        // Clear discards a partial block and blocks the offered sample.
        cycle("clr.pre", 1'b1, 3'd1, 1'b0, 1'b1, 1'b0);
        cycle("clr.pre", 1'b1, 3'd1, 1'b0, 1'b1, 1'b0);
        cycle("clr", 1'b1, 3'd1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle("clr.post", 1'b1, 3'd1, 1'b0, 1'b1, 1'b0);
        chk("clr.sum", {27'd0, data_out}, 32'd4);
        cycle("clr.drain", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-block.
        for (int i = 0; i < 3; i++) cycle("rst.pre", 1'b1, 3'd5, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1;
        rst = 1'b1;
        #2;
        chk("rst.async.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.async.data_out", {27'd0, data_out}, 32'd0);
        chk("rst.async.in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rst.held.in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst.held.out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) cycle("rst.post", 1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        chk("rst.post.sum", {27'd0, data_out}, 32'd8);
        cycle("rst.drain", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
